// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I execute stage.
//   alu_op_e : 4-bit ALU operation codes
//   OP_*     : 7-bit major opcodes used by the decoder
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11,
    ALU_EQ    = 4'd12,
    ALU_NE    = 4'd13,
    ALU_GE    = 4'd14,
    ALU_GEU   = 4'd15
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/rv32i_alu_unit_adder.sv
// 32-bit adder/subtractor.
//   in0, in1 : operands
//   sub      : 1 = in0 - in1, 0 = in0 + in1
//   out      : wrapped 32-bit result
module adder_bit32 (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        sub,
  output logic [31:0] out
);

  // Two's complement subtract: invert in1 and inject the carry-in.
  assign out = in0 + (in1 ^ {32{sub}}) + {31'd0, sub};

endmodule

// File: rtl/rv32i_alu_unit.sv
// Execute-stage ALU for the multicycle RV32I core.
//   clk, reset (async, active low), en : capture control
//   opcode, funct3, funct7, immediate  : decoded instruction fields
//   rs1_val, rs2_val, pc               : operands (already muxed) and PC
//   alu_op, rd_val                     : combinational decode and result
//   ex_rd_val, ex_valid                : registered result and strobe
//   pc_next_inc, pc_plus_imm           : combinational PC adders
module rv32i_alu_unit
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [20:0] immediate,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] pc,
  output logic [3:0]  alu_op,
  output logic [31:0] rd_val,
  output logic [31:0] ex_rd_val,
  output logic        ex_valid,
  output logic [31:0] pc_next_inc,
  output logic [31:0] pc_plus_imm
);

  alu_op_e     op;
  logic [31:0] add_in1;
  logic [31:0] add_out;
  logic [31:0] imm_ext;
  logic [4:0]  shamt;
  logic        unused_funct7;

  // Only funct7[5] distinguishes operations in RV32I.
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Decoder
  always_comb begin
    op = ALU_ADD;
    case (opcode)
      OP_R, OP_I: begin
        case (funct3)
          3'b000: op = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: op = ALU_SLL;
          3'b010: op = ALU_SLT;
          3'b011: op = ALU_SLTU;
          3'b100: op = ALU_XOR;
          // I-type shifts carry the arithmetic flag in imm[10] (instr[30]).
          3'b101: begin
            if (opcode == OP_R) op = funct7[5] ? ALU_SRA : ALU_SRL;
            else                op = immediate[10] ? ALU_SRA : ALU_SRL;
          end
          3'b110: op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      OP_LUI:   op = ALU_LUI;
      OP_AUIPC: op = ALU_AUIPC;
      OP_BRANCH: begin
        case (funct3)
          3'b000:  op = ALU_EQ;
          3'b001:  op = ALU_NE;
          3'b100:  op = ALU_SLT;
          3'b101:  op = ALU_GE;
          3'b110:  op = ALU_SLTU;
          3'b111:  op = ALU_GEU;
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  assign alu_op = op;

  // Shared adder handles ADD, SUB and AUIPC; AUIPC pre-shifts the upper immediate.
  assign add_in1 = (op == ALU_AUIPC) ? (rs2_val << 12) : rs2_val;

  adder_bit32 u_alu_add (
    .in0 (rs1_val),
    .in1 (add_in1),
    .sub (op == ALU_SUB),
    .out (add_out)
  );

  assign shamt = rs2_val[4:0];

  // ALU
  always_comb begin
    rd_val = add_out;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AUIPC: rd_val = add_out;
      ALU_SLL:  rd_val = rs1_val << shamt;
      ALU_SLT:  rd_val = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
      ALU_SLTU: rd_val = {31'd0, rs1_val < rs2_val};
      ALU_XOR:  rd_val = rs1_val ^ rs2_val;
      ALU_SRL:  rd_val = rs1_val >> shamt;
      ALU_SRA:  rd_val = $unsigned($signed(rs1_val) >>> shamt);
      ALU_OR:   rd_val = rs1_val | rs2_val;
      ALU_AND:  rd_val = rs1_val & rs2_val;
      ALU_LUI:  rd_val = rs2_val << 12;
      ALU_EQ:   rd_val = {31'd0, rs1_val == rs2_val};
      ALU_NE:   rd_val = {31'd0, rs1_val != rs2_val};
      ALU_GE:   rd_val = {31'd0, $signed(rs1_val) >= $signed(rs2_val)};
      ALU_GEU:  rd_val = {31'd0, rs1_val >= rs2_val};
      default:  rd_val = add_out;
    endcase
  end

  assign imm_ext = {{11{immediate[20]}}, immediate};

  adder_bit32 u_pc_inc (
    .in0 (pc),
    .in1 (32'd4),
    .sub (1'b0),
    .out (pc_next_inc)
  );

  adder_bit32 u_pc_imm (
    .in0 (pc),
    .in1 (imm_ext),
    .sub (1'b0),
    .out (pc_plus_imm)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_rd_val <= 32'd0;
      ex_valid  <= 1'b0;
    end else begin
      ex_valid <= en;
      if (en) ex_rd_val <= rd_val;
    end
  end

endmodule

// File: tb/tb_rv32i_alu_unit.sv
module tb_rv32i_alu_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [20:0] immediate;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] pc;
  logic [3:0]  alu_op;
  logic [31:0] rd_val;
  logic [31:0] ex_rd_val;
  logic        ex_valid;
  logic [31:0] pc_next_inc;
  logic [31:0] pc_plus_imm;

  int checks = 0;
  int errors = 0;

  rv32i_alu_unit dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .immediate   (immediate),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .pc          (pc),
    .alu_op      (alu_op),
    .rd_val      (rd_val),
    .ex_rd_val   (ex_rd_val),
    .ex_valid    (ex_valid),
    .pc_next_inc (pc_next_inc),
    .pc_plus_imm (pc_plus_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [20:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_op;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [20:0] imm;
    logic [31:0] exp_inc;
    logic [31:0] exp_imm;
  } pcvec_t;

  vec_t   vecs[$];
  pcvec_t pcvecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [6:0] o, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [20:0] imm,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] eop, input logic [31:0] erd);
    vec_t v;
    v.name = n; v.opc = o; v.f3 = f3; v.f7 = f7; v.imm = imm;
    v.a = a; v.b = b; v.exp_op = eop; v.exp_rd = erd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    opcode = v.opc; funct3 = v.f3; funct7 = v.f7; immediate = v.imm;
    rs1_val = v.a; rs2_val = v.b;
  endtask

  initial begin
    // name, opcode, f3, f7, imm, rs1, rs2, exp alu_op, exp rd_val
    vecs.push_back(mk("r_add",    7'b0110011, 3'b000, 7'h00, 21'd0,     32'd5,        32'hFFFFFFF9, 4'd0,  32'hFFFFFFFE));
    vecs.push_back(mk("r_sub",    7'b0110011, 3'b000, 7'h20, 21'd0,     32'h80000000, 32'd1,        4'd1,  32'h7FFFFFFF));
    vecs.push_back(mk("i_sra",    7'b0010011, 3'b101, 7'h00, 21'h405,   32'h80000000, 32'd5,        4'd7,  32'hFC000000));
    vecs.push_back(mk("i_srl",    7'b0010011, 3'b101, 7'h00, 21'h005,   32'h80000000, 32'd5,        4'd6,  32'h04000000));
    vecs.push_back(mk("i_add_f7", 7'b0010011, 3'b000, 7'h20, 21'd3,     32'd10,       32'd3,        4'd0,  32'd13));
    vecs.push_back(mk("r_srl",    7'b0110011, 3'b101, 7'h00, 21'd0,     32'h80000000, 32'd31,       4'd6,  32'h00000001));
    vecs.push_back(mk("r_sra",    7'b0110011, 3'b101, 7'h20, 21'd0,     32'h80000000, 32'd31,       4'd7,  32'hFFFFFFFF));
    vecs.push_back(mk("r_sll",    7'b0110011, 3'b001, 7'h00, 21'd0,     32'd1,        32'd33,       4'd2,  32'd2));
    vecs.push_back(mk("r_slt",    7'b0110011, 3'b010, 7'h00, 21'd0,     32'hFFFFFFFF, 32'd1,        4'd3,  32'd1));
    vecs.push_back(mk("r_sltu",   7'b0110011, 3'b011, 7'h00, 21'd0,     32'hFFFFFFFF, 32'd1,        4'd4,  32'd0));
    vecs.push_back(mk("r_xor",    7'b0110011, 3'b100, 7'h00, 21'd0,     32'h0000F0F0, 32'h000000FF, 4'd5,  32'h0000F00F));
    vecs.push_back(mk("r_or",     7'b0110011, 3'b110, 7'h00, 21'd0,     32'h0000F0F0, 32'h000000FF, 4'd8,  32'h0000F0FF));
    vecs.push_back(mk("r_and",    7'b0110011, 3'b111, 7'h00, 21'd0,     32'h0000F0F0, 32'h000000FF, 4'd9,  32'h000000F0));
    vecs.push_back(mk("br_lt",    7'b1100011, 3'b100, 7'h00, 21'd0,     32'hFFFFFFFF, 32'd1,        4'd3,  32'd1));
    vecs.push_back(mk("br_ltu",   7'b1100011, 3'b110, 7'h00, 21'd0,     32'hFFFFFFFF, 32'd1,        4'd4,  32'd0));
    vecs.push_back(mk("br_ge",    7'b1100011, 3'b101, 7'h00, 21'd0,     32'hFFFFFFFF, 32'd1,        4'd14, 32'd0));
    vecs.push_back(mk("br_geu",   7'b1100011, 3'b111, 7'h00, 21'd0,     32'hFFFFFFFF, 32'd1,        4'd15, 32'd1));
    vecs.push_back(mk("br_eq",    7'b1100011, 3'b000, 7'h00, 21'd0,     32'd7,        32'd7,        4'd12, 32'd1));
    vecs.push_back(mk("br_ne",    7'b1100011, 3'b001, 7'h00, 21'd0,     32'd7,        32'd7,        4'd13, 32'd0));
    vecs.push_back(mk("br_ill",   7'b1100011, 3'b010, 7'h00, 21'd0,     32'd7,        32'd7,        4'd0,  32'd14));
    vecs.push_back(mk("lui",      7'b0110111, 3'b000, 7'h00, 21'hFFFFF, 32'd0,        32'h000FFFFF, 4'd10, 32'hFFFFF000));
    vecs.push_back(mk("auipc",    7'b0010111, 3'b000, 7'h00, 21'd1,     32'h00000100, 32'd1,        4'd11, 32'h00001100));
    vecs.push_back(mk("load",     7'b0000011, 3'b010, 7'h20, 21'd0,     32'd100,      32'hFFFFFFFC, 4'd0,  32'd96));
    vecs.push_back(mk("store",    7'b0100011, 3'b101, 7'h20, 21'd0,     32'd100,      32'd8,        4'd0,  32'd108));
    vecs.push_back(mk("jalr",     7'b1100111, 3'b000, 7'h00, 21'd0,     32'h00000201, 32'd2,        4'd0,  32'h00000203));
    vecs.push_back(mk("jal",      7'b1101111, 3'b111, 7'h00, 21'd0,     32'd4,        32'd4,        4'd0,  32'd8));
    vecs.push_back(mk("system",   7'b1110011, 3'b001, 7'h20, 21'd0,     32'd1,        32'd2,        4'd0,  32'd3));

    pcvecs.push_back('{32'h00000100, 21'd0,        32'h00000104, 32'h00000100});
    pcvecs.push_back('{32'h00000100, 21'h1FFFF8,   32'h00000104, 32'h000000F8});
    pcvecs.push_back('{32'hFFFFFFFC, 21'd8,        32'h00000000, 32'h00000004});
    pcvecs.push_back('{32'h00000000, 21'h0FFFFF,   32'h00000004, 32'h000FFFFF});
    pcvecs.push_back('{32'h00001000, 21'h100000,   32'h00001004, 32'hFFF01000});

    reset = 1'b0; en = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; immediate = 21'd0;
    rs1_val = 32'd0; rs2_val = 32'd0; pc = 32'd0;

    #1;
    check("rst_ex_rd_val", ex_rd_val, 32'd0);
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);

    // Combinational table, applied while still in reset (en ignored).
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      check({vecs[i].name, "_op"}, {28'd0, alu_op}, {28'd0, vecs[i].exp_op});
      check({vecs[i].name, "_rd"}, rd_val, vecs[i].exp_rd);
    end

    foreach (pcvecs[i]) begin
      pc = pcvecs[i].pc;
      immediate = pcvecs[i].imm;
      #1;
      check("pc_next_inc", pc_next_inc, pcvecs[i].exp_inc);
      check("pc_plus_imm", pc_plus_imm, pcvecs[i].exp_imm);
    end

    // Capture must not happen while reset is held, even with en=1.
    en = 1'b1;
    drive(vecs[0]);
    @(posedge clk); #1;
    check("hold_rst_ex_rd_val", ex_rd_val, 32'd0);
    check("hold_rst_ex_valid", {31'd0, ex_valid}, 32'd0);

    // Release reset between edges; first edge after release captures.
    @(negedge clk);
    reset = 1'b1;
    drive(vecs[0]);
    en = 1'b1;
    #1;
    check("pre_edge_ex_rd_val", ex_rd_val, 32'd0);
    @(posedge clk); #1;
    check("cap_add_ex_rd_val", ex_rd_val, 32'hFFFFFFFE);
    check("cap_add_ex_valid", {31'd0, ex_valid}, 32'd1);

    // en=0 holds the value and drops ex_valid.
    @(negedge clk);
    drive(vecs[1]);
    en = 1'b0;
    @(posedge clk); #1;
    check("hold_ex_rd_val", ex_rd_val, 32'hFFFFFFFE);
    check("hold_ex_valid", {31'd0, ex_valid}, 32'd0);

    // Back-to-back captures.
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check("cap_sub_ex_rd_val", ex_rd_val, 32'h7FFFFFFF);
    @(negedge clk);
    drive(vecs[2]);
    @(posedge clk); #1;
    check("cap_sra_ex_rd_val", ex_rd_val, 32'hFC000000);
    check("cap_sra_ex_valid", {31'd0, ex_valid}, 32'd1);

    // Mid-operation async reset with ex_rd_val = 0x1234.
    @(negedge clk);
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h00;
    rs1_val = 32'h00001234; rs2_val = 32'd0;
    @(posedge clk); #1;
    check("pre_rst_ex_rd_val", ex_rd_val, 32'h00001234);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_ex_rd_val", ex_rd_val, 32'd0);
    check("async_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_low_ex_rd_val", ex_rd_val, 32'd0);
    check("rst_low_ex_valid", {31'd0, ex_valid}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ex_rd_val", ex_rd_val, 32'h00001234);
    check("post_rst_ex_valid", {31'd0, ex_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
